// File: rtl/inst_execute.sv
// Execute stage: RV64I ALU, load/store effective address and an iterative
// RV64M MUL (low product). The result is registered and handed downstream
// through a valid/ready handshake.
module inst_execute #(
  parameter int XLEN          = 64,
  parameter int MUL_RADIX_LOG = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rd,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [XLEN-1:0]  op1,
  input  logic [XLEN-1:0]  op2,
  input  logic             imm_flag,
  input  logic             mem_acc,
  input  logic             load_flag,
  input  logic             write_back,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_result,
  output logic             out_mem_acc,
  output logic             out_load_flag,
  output logic             out_write_back
);

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  // Number of iterations a multiply needs; at most 64, so 7 bits suffice.
  localparam logic [6:0] MUL_STEPS = 7'(XLEN / MUL_RADIX_LOG);

  state_t            state;
  logic [6:0]        mul_cnt;
  logic [XLEN-1:0]   mul_acc;
  logic [XLEN-1:0]   mul_mcand;
  logic [XLEN-1:0]   mul_mplier;
  logic [4:0]        pend_rd;
  logic              pend_mem_acc;
  logic              pend_load_flag;
  logic              pend_write_back;

  logic              accept;
  logic              is_m_ext;
  logic              is_mul;
  logic              sra_sel;
  logic [5:0]        shamt;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   mul_step;

  // The stage only takes new work when idle and the result register is free
  // (or being drained in this same cycle); reset forces it closed.
  assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // M-extension only exists for register-register forms; address generation wins.
  assign is_m_ext = !imm_flag && (funct7 == 7'b0000001);
  assign is_mul   = !mem_acc && is_m_ext && (funct3 == 3'b000);
  assign sra_sel  = imm_flag ? op2[10] : funct7[5];
  assign shamt    = op2[5:0];

  // Single-cycle result: effective address, M-ext zero result, or RV64I ALU op.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    alu_result = '0;
    if (mem_acc) begin
      alu_result = op1 + op2;
    end else if (is_m_ext) begin
      alu_result = '0;
    end else begin
      case (funct3)
        3'b000:  alu_result = (!imm_flag && funct7 == 7'b0100000) ? op1 - op2 : op1 + op2;
        3'b001:  alu_result = op1 << shamt;
        3'b010:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
        3'b011:  alu_result = {{(XLEN-1){1'b0}}, (op1 < op2)};
        3'b100:  alu_result = op1 ^ op2;
        3'b101:  alu_result = sra_sel ? $unsigned($signed(op1) >>> shamt) : op1 >> shamt;
        3'b110:  alu_result = op1 | op2;
        default: alu_result = op1 & op2;
      endcase
    end
  end

  // One multiply iteration: fold MUL_RADIX_LOG partial products into the accumulator.
  always_comb begin
    mul_step = mul_acc;
    for (int i = 0; i < MUL_RADIX_LOG; i++) begin
      if (mul_mplier[i]) begin
        mul_step = mul_step + (mul_mcand << i);
      end
    end
  end

  // Control FSM, result register and multiplier datapath.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state           <= IDLE;
      mul_cnt         <= '0;
      mul_acc         <= '0;
      mul_mcand       <= '0;
      mul_mplier      <= '0;
      pend_rd         <= '0;
      pend_mem_acc    <= 1'b0;
      pend_load_flag  <= 1'b0;
      pend_write_back <= 1'b0;
      out_valid       <= 1'b0;
      out_rd          <= '0;
      out_result      <= '0;
      out_mem_acc     <= 1'b0;
      out_load_flag   <= 1'b0;
      out_write_back  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_mul) begin
            // The previous result (if any) retires now; the product arrives later.
            mul_acc         <= '0;
            mul_mcand       <= op1;
            mul_mplier      <= op2;
            mul_cnt         <= MUL_STEPS;
            pend_rd         <= rd;
            pend_mem_acc    <= mem_acc;
            pend_load_flag  <= load_flag;
            pend_write_back <= write_back && (rd != 5'd0);
            out_valid       <= 1'b0;
            state           <= MUL_BUSY;
          end else if (accept) begin
            out_valid       <= 1'b1;
            out_rd          <= rd;
            out_result      <= alu_result;
            out_mem_acc     <= mem_acc;
            out_load_flag   <= load_flag;
            out_write_back  <= write_back && (rd != 5'd0);
          end else if (out_ready) begin
            out_valid       <= 1'b0;
          end
        end
        MUL_BUSY: begin
          mul_acc    <= mul_step;
          mul_mcand  <= mul_mcand << MUL_RADIX_LOG;
          mul_mplier <= mul_mplier >> MUL_RADIX_LOG;
          mul_cnt    <= mul_cnt - 7'd1;
          if (mul_cnt == 7'd1) begin
            out_valid      <= 1'b1;
            out_result     <= mul_step;
            out_rd         <= pend_rd;
            out_mem_acc    <= pend_mem_acc;
            out_load_flag  <= pend_load_flag;
            out_write_back <= pend_write_back;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
